// File: rtl/mips_cpu_regfile_wb_arbiter_if.sv
// mips_cpu_regfile_wb_arbiter_if: write-back port bundle between pipeline stages and the register file arbiter.
interface mips_cpu_regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_reg;
  logic [1:0]  ld_issue_kind;
  logic [1:0]  ld_issue_offset;
  logic        ld_ret_valid;
  logic [31:0] ld_ret_data;
  logic [4:0]  chk_reg_1;
  logic [4:0]  chk_reg_2;
  logic        hazard;
  logic        ld_ret_err;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_orwrite;
  logic        rf_loadlorloadr;
  logic [1:0]  rf_shiftdata;
  modport master (
    output alu_valid, alu_reg, alu_data, ld_issue_valid, ld_issue_reg, ld_issue_kind,
           ld_issue_offset, ld_ret_valid, ld_ret_data, chk_reg_1, chk_reg_2,
    input  alu_ready, ld_issue_ready, hazard, ld_ret_err, rf_write_enable, rf_write_reg,
           rf_write_data, rf_orwrite, rf_loadlorloadr, rf_shiftdata
  );
  modport slave (
    input  alu_valid, alu_reg, alu_data, ld_issue_valid, ld_issue_reg, ld_issue_kind,
           ld_issue_offset, ld_ret_valid, ld_ret_data, chk_reg_1, chk_reg_2,
    output alu_ready, ld_issue_ready, hazard, ld_ret_err, rf_write_enable, rf_write_reg,
           rf_write_data, rf_orwrite, rf_loadlorloadr, rf_shiftdata
  );
endinterface

// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// mips_cpu_regfile_wb_arbiter: shares the register file write port between ALU results and in-order load returns.
// Define MIPS_CPU_WB_SCOREBOARD_EN to enable load-use hazard and WAW stall detection.
module mips_cpu_regfile_wb_arbiter #(
  parameter int LQ_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  mips_cpu_regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] kind;
    logic [1:0] off;
  } entry_t;
  entry_t q [LQ_DEPTH];
  entry_t h;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic err, push, pop, waw, hz, merge;
  always_comb begin
    waw = 1'b0;
    hz = 1'b0;
`ifdef MIPS_CPU_WB_SCOREBOARD_EN
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if ({1'b0, AW'(AW'(i) - head)} < count && q[i].rd != 5'd0) begin
        hz = hz || q[i].rd == bus.chk_reg_1 || q[i].rd == bus.chk_reg_2;
        waw = waw || q[i].rd == bus.alu_reg;
      end
    end
`endif
  end
`ifndef MIPS_CPU_WB_SCOREBOARD_EN
  logic unused_chk;
  assign unused_chk = ^{bus.chk_reg_1, bus.chk_reg_2};
`endif
  // A load return cannot be stalled, so it always owns the write port.
  always_comb begin
    h = q[head];
    pop = bus.ld_ret_valid && count != '0;
    bus.ld_issue_ready = !reset && count < CW'(LQ_DEPTH);
    bus.alu_ready = !reset && !pop && !waw;
    push = bus.ld_issue_valid && bus.ld_issue_ready;
    merge = h.kind == 2'd1 || h.kind == 2'd2;
    bus.rf_write_enable = 1'b0;
    bus.rf_write_reg = 5'd0;
    bus.rf_write_data = 32'd0;
    bus.rf_orwrite = 1'b0;
    bus.rf_loadlorloadr = 1'b0;
    bus.rf_shiftdata = 2'd0;
    if (!reset && pop) begin
      bus.rf_write_enable = h.rd != 5'd0;
      bus.rf_write_reg = h.rd;
      bus.rf_write_data = h.kind == 2'd1 ? bus.ld_ret_data << {h.off, 3'b000}
                        : h.kind == 2'd2 ? bus.ld_ret_data >> {2'd3 - h.off, 3'b000}
                        : bus.ld_ret_data;
      bus.rf_orwrite = merge;
      bus.rf_loadlorloadr = h.kind == 2'd2;
      bus.rf_shiftdata = merge ? h.off : 2'd0;
    end else if (bus.alu_valid && bus.alu_ready) begin
      bus.rf_write_enable = bus.alu_reg != 5'd0;
      bus.rf_write_reg = bus.alu_reg;
      bus.rf_write_data = bus.alu_data;
    end
  end
  assign bus.hazard = hz && !reset;
  assign bus.ld_ret_err = err && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      if (push) begin
        q[tail] <= '{rd: bus.ld_issue_reg, kind: bus.ld_issue_kind, off: bus.ld_issue_offset};
        tail <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (bus.ld_ret_valid && count == '0) err <= 1'b1;
    end
  end
endmodule
